// File: rtl/pmod_mux_pkg.sv
// Shared constants and types for the Pmod port multiplexer.
package pmod_mux_pkg;

  localparam int MODE_UART = 0;
  localparam int MODE_SPI  = 1;
  localparam int MODE_GPIO = 2;
  localparam int MODE_I2C  = 3;

  typedef enum logic {
    GUARD  = 1'b0,
    ACTIVE = 1'b1
  } muxState_t;

  // Idle input level for parked channels; the top slices this to PINS bits.
  localparam logic [31:0] IDLE_IN_ALL = 32'hFFFF_FFFF;

  function automatic int cntWidth(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pmod_sync_bits.sv
// Multi-stage synchroniser for a bus of independent pin inputs.
module pmod_sync_bits #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bitsAsync,
  output logic [WIDTH-1:0] bitsSync
);

  logic [WIDTH-1:0] stageQ [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) stageQ[s] <= RESET_VAL;
    end else begin
      stageQ[0] <= bitsAsync;
      for (int s = 1; s < STAGES; s++) stageQ[s] <= stageQ[s-1];
    end
  end

  assign bitsSync = stageQ[STAGES-1];

endmodule

// File: rtl/pmod_port_mux_sync.sv
// Clocked Pmod connector multiplexer with high-Z guard on every mode switch.
//   state  | meaning
//   GUARD  | pins released, inputs idle, counting down toward target mode
//   ACTIVE | mode_cur slice drives the pins and receives synchronised inputs
module pmod_port_mux_sync
  import pmod_mux_pkg::*;
#(
  parameter int              PINS         = 4,
  parameter int              MODES        = 4,
  parameter int              GUARD_CYCLES = 4,
  parameter int              SYNC_STAGES  = 2,
  parameter int              RESET_MODE   = MODE_UART,
  localparam int             SELW         = $clog2(MODES),
  parameter logic [PINS-1:0] IDLE_IN      = IDLE_IN_ALL[PINS-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SELW-1:0]       mode_req,
  input  logic                  mode_req_valid,
  output logic                  mode_busy,
  output logic [SELW-1:0]       mode_cur,
  output logic                  mode_err,
  input  logic [MODES*PINS-1:0] periph_out,
  input  logic [MODES*PINS-1:0] periph_oe,
  output logic [MODES*PINS-1:0] periph_in,
  input  logic [PINS-1:0]       pin_i,
  output logic [PINS-1:0]       pin_o,
  output logic [PINS-1:0]       pin_oe
);

  localparam int              CNTW       = cntWidth(GUARD_CYCLES);
  localparam logic [CNTW-1:0] CNT_LOAD   = CNTW'(GUARD_CYCLES - 1);
  localparam logic [SELW-1:0] RESET_SEL  = SELW'(RESET_MODE);
  localparam logic [SELW:0]   MODE_LIMIT = (SELW + 1)'(MODES);

  muxState_t       stateQ, stateD;
  logic [SELW-1:0] modeCurQ, modeCurD;
  logic [SELW-1:0] targetQ, targetD;
  logic [CNTW-1:0] cntQ, cntD;
  logic            errQ, errD;
  logic            reqInRange, reqOk;
  logic            driveOk;

  logic [PINS-1:0]       selOut, selOe;
  logic [PINS-1:0]       pinSync;
  logic [PINS-1:0]       pinOQ, pinOeQ;
  logic [MODES*PINS-1:0] periphInD;

  pmod_sync_bits #(
    .WIDTH     (PINS),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (IDLE_IN)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .bitsAsync (pin_i),
    .bitsSync  (pinSync)
  );

  assign reqInRange = ({1'b0, mode_req} < MODE_LIMIT);
  assign reqOk      = mode_req_valid && reqInRange;

  always_comb begin
    stateD   = stateQ;
    modeCurD = modeCurQ;
    targetD  = targetQ;
    cntD     = cntQ;
    errD     = mode_req_valid && !reqInRange;
    case (stateQ)
      ACTIVE: begin
        if (reqOk && (mode_req != modeCurQ)) begin
          targetD = mode_req;
          cntD    = CNT_LOAD;
          stateD  = GUARD;
        end
      end
      GUARD: begin
        // A fresh request wins even on the exit cycle, so GUARD restarts directly.
        if (reqOk) begin
          targetD = mode_req;
          cntD    = CNT_LOAD;
        end else if (cntQ == '0) begin
          modeCurD = targetQ;
          stateD   = ACTIVE;
        end else begin
          cntD = cntQ - CNTW'(1);
        end
      end
      default: stateD = GUARD;
    endcase
  end

  always_comb begin
    selOut = '0;
    selOe  = '0;
    for (int m = 0; m < MODES; m++) begin
      if (modeCurQ == SELW'(m)) begin
        selOut = periph_out[m*PINS +: PINS];
        selOe  = periph_oe[m*PINS +: PINS];
      end
    end
  end

  // Drive only when ACTIVE both now and next, keeping pins quiet for the whole guard.
  assign driveOk = (stateQ == ACTIVE) && (stateD == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= GUARD;
      modeCurQ <= RESET_SEL;
      targetQ  <= RESET_SEL;
      cntQ     <= CNT_LOAD;
      errQ     <= 1'b0;
      pinOQ    <= '0;
      pinOeQ   <= '0;
    end else begin
      stateQ   <= stateD;
      modeCurQ <= modeCurD;
      targetQ  <= targetD;
      cntQ     <= cntD;
      errQ     <= errD;
      pinOQ    <= driveOk ? selOut : '0;
      pinOeQ   <= driveOk ? selOe  : '0;
    end
  end

  always_comb begin
    periphInD = {MODES{IDLE_IN}};
    if (stateQ == ACTIVE) begin
      for (int m = 0; m < MODES; m++) begin
        if (modeCurQ == SELW'(m)) periphInD[m*PINS +: PINS] = pinSync;
      end
    end
  end

  assign periph_in = periphInD;
  assign pin_o     = pinOQ;
  assign pin_oe    = pinOeQ;
  assign mode_busy = (stateQ == GUARD);
  assign mode_cur  = modeCurQ;
  assign mode_err  = errQ;

endmodule

// File: tb/tb_pmod_port_mux_sync.sv
// Randomised bench for pmod_port_mux_sync with a timestamp-based reference model.
module tb_pmod_port_mux_sync;

  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  modeReq = '0;
  logic        modeReqValid = 1'b0;
  logic        modeBusy, modeErr;
  logic [1:0]  modeCur;
  logic [15:0] periphOut = '0, periphOe = '0, periphIn;
  logic [3:0]  pinI = '0, pinO, pinOe;

  logic [1:0]  m3Req = '0;
  logic        m3Valid = 1'b0;
  logic        m3Busy, m3Err;
  logic [1:0]  m3Cur;
  logic [11:0] m3PeriphOut = '0, m3PeriphOe = '0, m3PeriphIn;
  logic [3:0]  m3PinI = '0, m3PinO, m3PinOe;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pmod_port_mux_sync #(.PINS(4), .MODES(4), .GUARD_CYCLES(G), .SYNC_STAGES(2), .RESET_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .mode_req(modeReq), .mode_req_valid(modeReqValid),
    .mode_busy(modeBusy), .mode_cur(modeCur), .mode_err(modeErr),
    .periph_out(periphOut), .periph_oe(periphOe), .periph_in(periphIn),
    .pin_i(pinI), .pin_o(pinO), .pin_oe(pinOe));

  pmod_port_mux_sync #(.PINS(4), .MODES(3), .GUARD_CYCLES(G), .SYNC_STAGES(2), .RESET_MODE(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode_req(m3Req), .mode_req_valid(m3Valid),
    .mode_busy(m3Busy), .mode_cur(m3Cur), .mode_err(m3Err),
    .periph_out(m3PeriphOut), .periph_oe(m3PeriphOe), .periph_in(m3PeriphIn),
    .pin_i(m3PinI), .pin_o(m3PinO), .pin_oe(m3PinOe));

  // Reference model: guard exit is a cycle timestamp; a request restarts it.
  int         cyc = 0;
  int         exitAt = G;
  logic       mBusy = 1'b1;
  logic [1:0] mMode = '0, mTarget = '0;
  logic       mWasActive, mReload;
  logic [3:0] expPinO = '0, expPinOe = '0;
  logic [3:0] hist [2] = '{4'hF, 4'hF};
  logic [15:0] expIn = 16'hFFFF;

  always @(posedge clk or negedge rst_n) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mBusy = 1'b1; mMode = '0; mTarget = '0; exitAt = cyc + G;
      expPinO = '0; expPinOe = '0; hist[0] = 4'hF; hist[1] = 4'hF;
    end else begin
      mWasActive = !mBusy;
      mReload = 1'b0;
      if (modeReqValid && (mBusy || modeReq != mMode)) begin
        mTarget = modeReq; exitAt = cyc + G; mBusy = 1'b1; mReload = 1'b1;
      end
      if (mBusy && !mReload && cyc == exitAt) begin
        mMode = mTarget; mBusy = 1'b0;
      end
      expPinO  = (mWasActive && !mBusy) ? periphOut[mMode*4 +: 4] : 4'h0;
      expPinOe = (mWasActive && !mBusy) ? periphOe[mMode*4 +: 4]  : 4'h0;
      hist[1] = hist[0];
      hist[0] = pinI;
    end
    expIn = 16'hFFFF;
    if (!mBusy) expIn[mMode*4 +: 4] = hist[1];
  end

  wire [27:0] dutVec   = {modeBusy, modeCur, modeErr, pinO, pinOe, periphIn};
  wire [27:0] modelVec = {mBusy, mMode, 1'b0, expPinO, expPinOe, expIn};

  task automatic drive_random();
    periphOut = 16'($urandom);
    periphOe  = 16'($urandom);
    pinI      = 4'($urandom);
  endtask

  task automatic test_reset();
    drive_random(); periphOe[3:0] = 4'b0010;
    repeat (3) @(negedge clk);
    compared++;
    if ({pinOe, pinO, modeBusy, modeCur, modeErr, periphIn} !== {8'h00, 1'b1, 2'd0, 1'b0, 16'hFFFF}) begin
      mismatched++; $display("FAIL reset_values got %h want %h", {pinOe, pinO, modeBusy, modeCur, modeErr, periphIn}, {8'h00, 1'b1, 2'd0, 1'b0, 16'hFFFF});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      compared++;
      if (modeBusy !== (i < 4)) begin mismatched++; $display("FAIL busy_after_release cycle %0d got %b want %b", i, modeBusy, (i < 4)); end
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_release got %h want %h", dutVec, modelVec); end
      drive_random(); periphOe[3:0] = 4'b0010;
    end
    @(negedge clk);
    compared++;
    if (pinOe !== 4'b0010) begin mismatched++; $display("FAIL reset_mode_drive got %b want 0010", pinOe); end
    periphOe[3:0] = 4'hF;
    @(negedge clk);
    compared++;
    if (pinOe !== 4'hF) begin mismatched++; $display("FAIL pre_reset_drive got %h want f", pinOe); end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({pinOe, modeBusy} !== {4'h0, 1'b1}) begin mismatched++; $display("FAIL async_reset got oe=%h busy=%b want oe=0 busy=1", pinOe, modeBusy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_rerelease got %h want %h", dutVec, modelVec); end
      drive_random();
    end
  endtask

  task automatic test_mode_change();
    int busyCycles = 0;
    drive_random(); periphOut[7:4] = 4'b1011; periphOe[7:4] = 4'b1011;
    modeReq = 2'd1; modeReqValid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      modeReqValid = 1'b0;
      if (modeBusy === 1'b1) busyCycles++;
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_mode_change cycle %0d got %h want %h", i, dutVec, modelVec); end
      if (i == 5) begin
        compared++;
        if ({modeCur, pinOe} !== {2'd1, 4'h0}) begin mismatched++; $display("FAIL exit_cycle got cur=%0d oe=%h want cur=1 oe=0", modeCur, pinOe); end
      end
      drive_random(); periphOut[7:4] = 4'b1011; periphOe[7:4] = 4'b1011;
    end
    compared++;
    if (busyCycles != G) begin mismatched++; $display("FAIL guard_length got %0d want %0d", busyCycles, G); end
    compared++;
    if ({pinO, pinOe, modeCur} !== {4'b1011, 4'b1011, 2'd1}) begin mismatched++; $display("FAIL new_mode_drive got %h want %h", {pinO, pinOe, modeCur}, {4'b1011, 4'b1011, 2'd1}); end
  endtask

  task automatic test_input_path();
    modeReq = 2'd3; modeReqValid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      modeReqValid = 1'b0;
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_to_mode3 got %h want %h", dutVec, modelVec); end
      drive_random();
    end
    pinI = 4'b0100;
    repeat (2) @(negedge clk);
    compared++;
    if (periphIn !== 16'h4FFF) begin mismatched++; $display("FAIL input_sync got %h want 4fff", periphIn); end
    repeat (20) begin
      drive_random();
      @(negedge clk);
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_input got %h want %h", dutVec, modelVec); end
    end
    modeReq = 2'd0; modeReqValid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      modeReqValid = 1'b0;
      if (i <= G) begin
        compared++;
        if (periphIn !== 16'hFFFF) begin mismatched++; $display("FAIL guard_inputs_idle cycle %0d got %h want ffff", i, periphIn); end
      end
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_to_mode0 got %h want %h", dutVec, modelVec); end
      drive_random();
    end
  endtask

  task automatic test_noop();
    modeReq = 2'd0; modeReqValid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      modeReqValid = 1'b0;
      compared++;
      if (modeBusy !== 1'b0) begin mismatched++; $display("FAIL noop_busy cycle %0d got %b want 0", i, modeBusy); end
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_noop got %h want %h", dutVec, modelVec); end
      drive_random();
    end
  endtask

  task automatic test_rerequest();
    bit found = 0;
    drive_random();
    periphOut[7:4] = 4'hF; periphOe[7:4] = 4'hF; periphOut[11:8] = 4'b0110; periphOe[11:8] = 4'b0101;
    modeReq = 2'd1; modeReqValid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      modeReqValid = 1'b0;
    end
    modeReq = 2'd2; modeReqValid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      modeReqValid = 1'b0;
      if (!found && modeCur === 2'd2) begin
        found = 1;
        compared++;
        if (k != G + 1) begin mismatched++; $display("FAIL rerequest_latency got %0d want %0d", k, G + 1); end
      end
      compared++;
      if (modeCur === 2'd1 || pinOe === 4'hF) begin mismatched++; $display("FAIL stale_mode_drove got cur=%0d oe=%h want cur!=1 oe!=f", modeCur, pinOe); end
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_rerequest got %h want %h", dutVec, modelVec); end
    end
    if (!found) begin mismatched++; $display("FAIL rerequest_timeout got cur=%0d want 2", modeCur); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      modeReq = 2'($urandom); modeReqValid = 1'b1;
      @(negedge clk);
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_b2b got %h want %h", dutVec, modelVec); end
      drive_random();
    end
    modeReqValid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_b2b_tail got %h want %h", dutVec, modelVec); end
      drive_random();
    end
  endtask

  task automatic test_random();
    repeat (300) begin
      modeReq = 2'($urandom);
      modeReqValid = ($urandom_range(0, 5) == 0);
      drive_random();
      @(negedge clk);
      compared++;
      if (dutVec !== modelVec) begin mismatched++; $display("FAIL model_random got %h want %h", dutVec, modelVec); end
    end
    modeReqValid = 1'b0;
  endtask

  task automatic test_out_of_range();
    m3Req = 2'd3; m3Valid = 1'b1;
    @(negedge clk);
    m3Valid = 1'b0;
    compared++;
    if ({m3Err, m3Busy, m3Cur} !== {1'b1, 1'b0, 2'd0}) begin mismatched++; $display("FAIL err_active got %b want 1000", {m3Err, m3Busy, m3Cur}); end
    @(negedge clk);
    compared++;
    if ({m3Err, m3Busy, m3Cur} !== {1'b0, 1'b0, 2'd0}) begin mismatched++; $display("FAIL err_pulse_width got %b want 0000", {m3Err, m3Busy, m3Cur}); end
    m3Req = 2'd1; m3Valid = 1'b1;
    @(negedge clk);
    m3Req = 2'd3;
    compared++;
    if ({m3Err, m3Busy} !== 2'b01) begin mismatched++; $display("FAIL m3_guard_entry got %b want 01", {m3Err, m3Busy}); end
    @(negedge clk);
    m3Valid = 1'b0;
    compared++;
    if ({m3Err, m3Busy, m3Cur} !== {1'b1, 1'b1, 2'd0}) begin mismatched++; $display("FAIL err_guard got %b want 1100", {m3Err, m3Busy, m3Cur}); end
    repeat (2) @(negedge clk);
    compared++;
    if ({m3Err, m3Busy, m3Cur} !== {1'b0, 1'b1, 2'd0}) begin mismatched++; $display("FAIL guard_kept_count got %b want 0100", {m3Err, m3Busy, m3Cur}); end
    @(negedge clk);
    compared++;
    if ({m3Err, m3Busy, m3Cur} !== {1'b0, 1'b0, 2'd1}) begin mismatched++; $display("FAIL guard_exit_unchanged got %b want 0001", {m3Err, m3Busy, m3Cur}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m3PeriphOut = 12'($urandom);
    m3PeriphOe  = 12'($urandom);
    m3PinI      = 4'($urandom);
    test_reset();
    test_mode_change();
    test_input_path();
    test_noop();
    test_rerequest();
    test_back_to_back();
    test_random();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
